// File: rtl/histo_bin_accum.sv
// Per-bin event histogram: forms bin address = row offset + x, accumulates
// saturating {neg, pos} counters in block RAM through a 4-stage
// read-modify-write pipeline, and on frame end drains and clears every bin
// as a valid/ready stream.
module histo_bin_accum #(
    parameter int BASE_W   = 26,
    parameter int X_W      = 16,
    parameter int ADDR_W   = 12,
    parameter int NUM_BINS = 4096,
    parameter int CNT_W    = 8
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BASE_W-1:0]    in_base,
    input  logic [X_W-1:0]       in_x,
    input  logic                 in_pol,
    input  logic                 frame_end,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*CNT_W-1:0]   out_data,
    output logic                 out_last,
    output logic [31:0]          drop_cnt,
    output logic                 busy
);
    localparam int WORD_W = 2 * CNT_W;
    localparam int SUM_W  = BASE_W + 1;
    localparam logic [SUM_W-1:0]  BIN_LIMIT = SUM_W'(NUM_BINS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {ST_CLEAR, ST_ACCUM, ST_FLUSH, ST_DRAIN} state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] clr_addr_reg;

    // accumulate pipeline registers
    logic              a1_valid_reg, a2_valid_reg, a3_valid_reg, wb_valid_reg;
    logic [ADDR_W-1:0] a1_addr_reg, a2_addr_reg, a3_addr_reg, wb_addr_reg;
    logic              a1_pol_reg, a2_pol_reg;
    logic [WORD_W-1:0] a3_data_reg, wb_data_reg;
    logic [31:0]       drop_cnt_reg;

    // drain read side and 2-entry skid buffer
    logic [ADDR_W-1:0] drn_addr_reg;
    logic              drn_issued_all_reg;
    logic              drn_rd_valid_reg;
    logic              drn_rd_last_reg;
    logic [1:0]        sk_cnt_reg;
    logic [WORD_W-1:0] sk_data_reg [0:1];
    logic              sk_last_reg [0:1];

    // block RAM
    logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [WORD_W-1:0] rd_data_reg;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr;
    logic [WORD_W-1:0] mem_wdata;

    logic              accept;
    logic [SUM_W-1:0]  addr_sum;
    logic              in_range;
    logic              pipe_busy;
    logic              pop;
    logic [2:0]        sk_occ;
    logic              drn_issue;
    logic [WORD_W-1:0] a2_word;
    logic [WORD_W-1:0] a2_result;

    assign accept    = in_valid & in_ready;
    // one extra bit so a carry out of the row offset can never alias into range
    assign addr_sum  = {1'b0, in_base} + SUM_W'(in_x);
    assign in_range  = (addr_sum < BIN_LIMIT);
    assign pipe_busy = a1_valid_reg | a2_valid_reg | a3_valid_reg;
    assign pop       = out_valid & out_ready;
    // words held or in flight after this cycle's pop; a new read needs a free slot
    assign sk_occ    = 3'(sk_cnt_reg) + 3'(drn_rd_valid_reg) - 3'(pop);
    assign drn_issue = (state_reg == ST_DRAIN) && !drn_issued_all_reg && (sk_occ <= 3'd1);

    // state register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg <= ST_CLEAR;
        end else begin
            state_reg <= state_next;
        end
    end

    // next-state decode
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CLEAR: if (clr_addr_reg == LAST_ADDR) state_next = ST_ACCUM;
            ST_ACCUM: if (frame_end) state_next = ST_FLUSH;
            ST_FLUSH: if (!pipe_busy) state_next = ST_DRAIN;
            ST_DRAIN: if (pop && sk_last_reg[0]) state_next = ST_ACCUM;
            default:  state_next = ST_CLEAR;
        endcase
    end

    // state-derived outputs
    always_comb begin
        in_ready  = (state_reg == ST_ACCUM);
        busy      = (state_reg != ST_ACCUM) || pipe_busy;
        out_valid = (sk_cnt_reg != 2'd0);
        out_data  = sk_data_reg[0];
        out_last  = out_valid && sk_last_reg[0];
        drop_cnt  = drop_cnt_reg;
    end

    // clear sweep address, one bin per cycle
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            clr_addr_reg <= '0;
        end else if (state_reg == ST_CLEAR) begin
            clr_addr_reg <= clr_addr_reg + ADDR_W'(1);
        end
    end

    // memory port steering: clear sweep, drain read+zero, or accumulate
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = a3_addr_reg;
        mem_wdata = a3_data_reg;
        mem_re    = a1_valid_reg;
        mem_raddr = a1_addr_reg;
        case (state_reg)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr_reg;
                mem_wdata = '0;
            end
            ST_DRAIN: begin
                mem_we    = drn_issue;
                mem_waddr = drn_addr_reg;
                mem_wdata = '0;
                mem_re    = drn_issue;
                mem_raddr = drn_addr_reg;
            end
            default: mem_we = a3_valid_reg;
        endcase
    end

    // block RAM, read returns the pre-write contents on a same-address collision
    always_ff @(posedge ap_clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (mem_re) rd_data_reg <= mem[mem_raddr];
    end

    // pick freshest copy of the bin: pending write, last write, else RAM
    always_comb begin
        a2_word = rd_data_reg;
        if (a3_valid_reg && (a3_addr_reg == a2_addr_reg)) begin
            a2_word = a3_data_reg;
        end else if (wb_valid_reg && (wb_addr_reg == a2_addr_reg)) begin
            a2_word = wb_data_reg;
        end
    end

    // saturating increment of the selected half (0 = pos, 1 = neg)
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_half
            logic [CNT_W-1:0] half;
            logic             bump;
            assign half = a2_word[gi*CNT_W +: CNT_W];
            assign bump = (gi == 0) ? a2_pol_reg : ~a2_pol_reg;
            assign a2_result[gi*CNT_W +: CNT_W] =
                (bump && (half != CNT_MAX)) ? half + CNT_W'(1) : half;
        end
    endgenerate

    // pipeline valids and drop counter
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            a1_valid_reg <= 1'b0;
            a2_valid_reg <= 1'b0;
            a3_valid_reg <= 1'b0;
            wb_valid_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            a1_valid_reg <= accept && in_range;
            a2_valid_reg <= a1_valid_reg;
            a3_valid_reg <= a2_valid_reg;
            wb_valid_reg <= a3_valid_reg;
            if (accept && !in_range) drop_cnt_reg <= drop_cnt_reg + 32'd1;
        end
    end

    // pipeline payload, qualified by the valids above
    always_ff @(posedge ap_clk) begin
        a1_addr_reg <= addr_sum[ADDR_W-1:0];
        a1_pol_reg  <= in_pol;
        a2_addr_reg <= a1_addr_reg;
        a2_pol_reg  <= a1_pol_reg;
        a3_addr_reg <= a2_addr_reg;
        a3_data_reg <= a2_result;
        wb_addr_reg <= a3_addr_reg;
        wb_data_reg <= a3_data_reg;
    end

    // drain read sequencer
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            drn_addr_reg       <= '0;
            drn_issued_all_reg <= 1'b0;
            drn_rd_valid_reg   <= 1'b0;
            drn_rd_last_reg    <= 1'b0;
        end else begin
            if (state_reg == ST_FLUSH) begin
                drn_addr_reg       <= '0;
                drn_issued_all_reg <= 1'b0;
            end else if (drn_issue) begin
                drn_addr_reg <= drn_addr_reg + ADDR_W'(1);
                if (drn_addr_reg == LAST_ADDR) drn_issued_all_reg <= 1'b1;
            end
            drn_rd_valid_reg <= drn_issue;
            drn_rd_last_reg  <= drn_issue && (drn_addr_reg == LAST_ADDR);
        end
    end

    // skid buffer: entry 0 is the presented word, entry 1 absorbs RAM latency
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            sk_cnt_reg     <= 2'd0;
            sk_data_reg[0] <= '0;
            sk_data_reg[1] <= '0;
            sk_last_reg[0] <= 1'b0;
            sk_last_reg[1] <= 1'b0;
        end else begin
            case ({drn_rd_valid_reg, pop})
                2'b10: begin
                    if (sk_cnt_reg == 2'd0) begin
                        sk_data_reg[0] <= rd_data_reg;
                        sk_last_reg[0] <= drn_rd_last_reg;
                        sk_cnt_reg     <= 2'd1;
                    end else begin
                        sk_data_reg[1] <= rd_data_reg;
                        sk_last_reg[1] <= drn_rd_last_reg;
                        sk_cnt_reg     <= 2'd2;
                    end
                end
                2'b01: begin
                    if (sk_cnt_reg == 2'd2) begin
                        sk_data_reg[0] <= sk_data_reg[1];
                        sk_last_reg[0] <= sk_last_reg[1];
                    end
                    sk_cnt_reg <= sk_cnt_reg - 2'd1;
                end
                2'b11: begin
                    if (sk_cnt_reg == 2'd1) begin
                        sk_data_reg[0] <= rd_data_reg;
                        sk_last_reg[0] <= drn_rd_last_reg;
                    end else begin
                        sk_data_reg[0] <= sk_data_reg[1];
                        sk_last_reg[0] <= sk_last_reg[1];
                        sk_data_reg[1] <= rd_data_reg;
                        sk_last_reg[1] <= drn_rd_last_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/histo_bin_accum.md
Name: histo_bin_accum

Overview:
- Downstream consumer of the 16x16 row-offset multiplier (product = y*FRAME_W, 26 bits, 4-cycle latency) in the histoframe accelerator.
- Adds x to the row offset to form a bin address, then read-modify-writes per-polarity saturating counters in on-chip BRAM.
- On frame end, drains every bin in address order as a valid/ready stream to the frame writer, clearing each bin as it is read.

Parameters:
- BASE_W, 26, width of row-offset input (multiplier product width)
- X_W, 16, width of x coordinate
- ADDR_W, 12, bin address width; memory depth 2^ADDR_W
- NUM_BINS, 4096, valid bins (FRAME_W*FRAME_H), NUM_BINS <= 2^ADDR_W
- CNT_W, 8, per-polarity counter width

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous active-high reset
- in_valid  in  1  event valid
- in_ready  out  1  block accepts event
- in_base  in  BASE_W  row offset y*FRAME_W from multiplier
- in_x  in  X_W  x coordinate
- in_pol  in  1  polarity (1 = pos, 0 = neg)
- frame_end  in  1  single-cycle pulse: close frame, start drain
- out_valid  out  1  bin word valid
- out_ready  in  1  downstream accepts word
- out_data  out  2*CNT_W  {neg_cnt, pos_cnt}
- out_last  out  1  high with word for bin NUM_BINS-1
- drop_cnt  out  32  events dropped for address >= NUM_BINS; cleared by reset only, wraps
- busy  out  1  high in CLEAR, FLUSH and DRAIN

Behaviour:
- Reset: in_ready=0, out_valid=0, out_last=0, out_data=0, drop_cnt=0, busy=1; state <= CLEAR. Reset mid-drain or mid-accumulate aborts and restarts CLEAR.
- States: CLEAR -> ACCUM -> FLUSH -> DRAIN -> ACCUM.
- CLEAR: writes 0 to addresses 0..NUM_BINS-1 at one per cycle. After the last write, state goes to ACCUM. in_ready rises exactly NUM_BINS cycles after reset deasserts.
- ACCUM:
  - in_ready=1; a transfer occurs when in_valid & in_ready.
  - Address addr = in_base + in_x, computed at BASE_W+1 bits with no truncation before the compare.
  - If addr >= NUM_BINS: event dropped, drop_cnt += 1, memory untouched.
- Accumulate pipeline, 1 event/cycle with no stalls:
  - A0: accept and register addr/pol.
  - A1: BRAM read issued.
  - A2: data returned; selected half incremented, saturating at 2^CNT_W-1; the other half unchanged.
  - A3: write.
  - Memory is updated 3 cycles after acceptance.
- Hazards: read-during-write returns old data. A2 must forward from the A3 write register and from the prior-cycle write register when addresses match. Every event counts exactly once for any spacing, including back-to-back identical addresses.
- frame_end:
  - Sampled only in ACCUM. An event accepted in the same cycle as frame_end belongs to the current frame.
  - in_ready drops the next cycle and state enters FLUSH.
  - frame_end in any other state is ignored.
- FLUSH: waits until pipeline stages A1..A3 are empty (at most 3 cycles), then enters DRAIN at read address 0.
- DRAIN:
  - Reads bins 0..NUM_BINS-1 in order and presents each as out_data; writes 0 back to each bin after it is read.
  - First out_valid occurs 2 cycles after DRAIN entry.
  - out_valid/out_data/out_last are held stable until out_ready. Words are never dropped or duplicated.
  - Sustains 1 word/cycle with out_ready held high; uses a 2-entry skid buffer to absorb BRAM read latency.
  - After the transfer with out_last=1, state returns to ACCUM and in_ready=1 the next cycle.
- Counters never wrap; saturation is silent.
- busy = (state != ACCUM) or pipeline not empty.

Test Plan:
- Reset hold 5 cycles, release -> in_ready=0 for 4096 cycles, then 1; drain immediately -> 4096 words all 0, out_last only on word 4095.
- Events (base=64,x=3,pol=1) x3 back-to-back plus (base=64,x=3,pol=0) x1, frame_end -> bin 67 = {neg 1, pos 3}; all other bins 0.
- 300 consecutive pos events to bin 10, CNT_W=8 -> bin 10 pos=255, neg=0 (saturation).
- base=4090, x=10 (addr 4100) -> drop_cnt=1, no bin changed; a second drain shows all zeros.
- Drain with out_ready toggling 1,0,0,1 pseudo-randomly -> word sequence identical to the out_ready=1 case; a following frame starts from zeros.
- Assert ap_rst mid-drain at word 100 -> out_valid=0 next cycle, CLEAR re-runs, next drain all zeros.
